// File: rtl/vga_pkg.sv
// Shared frame-buffer definitions: geometry, pixel type, read tags, arbiter states.
package vga_pkg;
    localparam int VGA_FB_W     = 160;
    localparam int VGA_FB_H     = 120;
    localparam int VGA_FB_WORDS = VGA_FB_W * VGA_FB_H;
    localparam int VGA_ADDR_W   = 15;
    localparam int VGA_PIX_W    = 3;

    typedef logic [VGA_PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_DRAW = 2'd2
    } rd_tag_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;
endpackage

// File: rtl/vga_fb_clear_seq.sv
// Clear sequencer: walks a pointer over 0..FB_WORDS-1, advancing only on
// cycles the arbiter grants it a RAM slot. Start requests while busy are ignored.
module vga_fb_clear_seq
    import vga_pkg::*;
#(
    parameter int ADDR_W   = VGA_ADDR_W,
    parameter int FB_WORDS = VGA_FB_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_gnt,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_busy
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_WORDS - 1);

    arb_state_e        r_state, w_state_nx;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nx;

    // State and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    // Next state: load pointer on start, step on grant, finish after last word
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nx = ST_CLEAR;
                    w_ptr_nx   = '0;
                end
            end
            ST_CLEAR: begin
                if (i_gnt) begin
                    if (r_ptr == LAST) begin
                        w_state_nx = ST_IDLE;
                        w_ptr_nx   = '0;
                    end else begin
                        w_ptr_nx = r_ptr + 1'b1;
                    end
                end
            end
        endcase
    end

    assign o_ptr  = r_ptr;
    assign o_busy = (r_state == ST_CLEAR);
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display > clear > draw, one RAM access per cycle.
// Optional draw readback enabled by defining VGA_FB_READBACK_EN.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int                ADDR_W      = VGA_ADDR_W,
    parameter int                DATA_W      = VGA_PIX_W,
    parameter int                FB_WORDS    = VGA_FB_WORDS,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              draw_valid,
    output logic              draw_ready,
    input  logic              draw_we,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    output logic              draw_rvalid,
    output logic [DATA_W-1:0] draw_rdata,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic [15:0]       stall_cnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam logic [ADDR_W:0] FB_LIM = (ADDR_W+1)'(FB_WORDS);

    logic              w_clr_busy, w_clr_gnt, w_xfer, w_in_rng, w_draw_wr, w_draw_rd;
    logic [ADDR_W-1:0] w_clr_ptr;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata;
    rd_tag_e           r_tag0, r_tag1;
    logic              r_disp_valid;
    logic [DATA_W-1:0] r_disp_data;
    logic [15:0]       r_stall;

    vga_fb_clear_seq #(.ADDR_W(ADDR_W), .FB_WORDS(FB_WORDS)) u_clr (
        .clk    (clk),
        .rst    (rst),
        .i_start(clear_start),
        .i_gnt  (w_clr_gnt),
        .o_ptr  (w_clr_ptr),
        .o_busy (w_clr_busy)
    );

    assign draw_ready = !disp_req && !w_clr_busy;
    assign w_xfer     = draw_valid && draw_ready;
    assign w_clr_gnt  = w_clr_busy && !disp_req;
    assign w_in_rng   = ({1'b0, draw_addr} < FB_LIM);

`ifdef VGA_FB_READBACK_EN
    assign w_draw_wr = w_xfer && draw_we;
    assign w_draw_rd = w_xfer && !draw_we;
`else
    logic w_unused_we;
    assign w_unused_we = draw_we;
    assign w_draw_wr   = w_xfer;
    assign w_draw_rd   = 1'b0;
`endif

    // RAM command register; address/data hold when nothing is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_we <= 1'b0;
            if (disp_req) begin
                r_ram_addr <= disp_addr;
            end else if (w_clr_gnt) begin
                r_ram_addr  <= w_clr_ptr;
                r_ram_wdata <= CLEAR_VALUE;
                r_ram_we    <= 1'b1;
            end else if (w_xfer) begin
                r_ram_addr <= draw_addr;
                if (w_draw_wr) begin
                    r_ram_wdata <= draw_wdata;
                    r_ram_we    <= w_in_rng;
                end
            end
        end
    end

    // Two-deep tag pipeline aligning each read with its returning data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag0 <= TAG_NONE;
            r_tag1 <= TAG_NONE;
        end else begin
            r_tag0 <= disp_req ? TAG_DISP : (w_draw_rd ? TAG_DRAW : TAG_NONE);
            r_tag1 <= r_tag0;
        end
    end

    // Display data capture, fixed three cycles after the request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
        end else begin
            r_disp_valid <= (r_tag1 == TAG_DISP);
            if (r_tag1 == TAG_DISP) r_disp_data <= ram_rdata;
        end
    end

`ifdef VGA_FB_READBACK_EN
    logic              r_zero0, r_zero1, r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    // Draw readback capture; out-of-range reads return zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero0  <= 1'b0;
            r_zero1  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_zero0  <= !w_in_rng;
            r_zero1  <= r_zero0;
            r_rvalid <= (r_tag1 == TAG_DRAW);
            if (r_tag1 == TAG_DRAW) r_rdata <= r_zero1 ? '0 : ram_rdata;
        end
    end

    assign draw_rvalid = r_rvalid;
    assign draw_rdata  = r_rdata;
`else
    assign draw_rvalid = 1'b0;
    assign draw_rdata  = '0;
`endif

    // Saturating count of stalled draw cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          r_stall <= '0;
        else if (draw_valid && !draw_ready && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
    end

    assign disp_valid = r_disp_valid;
    assign disp_data  = r_disp_data;
    assign clear_busy = w_clr_busy;
    assign stall_cnt  = r_stall;
    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_wdata  = r_ram_wdata;
endmodule
